// File: rtl/bus_pkg.sv
// Shared types and constants for the single-master bus fabric and its address decoder.
package bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Slot 0 occupies the least-significant 32 bits.
    localparam logic [4*ADDR_W-1:0] DEF_SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                                   32'h1000_0000, 32'h0000_0000};
    localparam logic [4*ADDR_W-1:0] DEF_SLV_MASK = {4{32'hF000_0000}};

endpackage

// File: rtl/bus_decode.sv
// Combinational address decoder: the lowest-index slot whose masked address matches its base wins.
module bus_decode
    import bus_pkg::*;
#(
    parameter int                          NUM_SLV  = 4,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE = DEF_SLV_BASE,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK = DEF_SLV_MASK,
    parameter int                          SLOT_W   = $clog2(NUM_SLV)
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o,
    output logic [SLOT_W-1:0] slot_o
);

    logic [NUM_SLV-1:0] match;

    generate
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_match
            assign match[gi] = (addr_i & SLV_MASK[gi*ADDR_W +: ADDR_W])
                               == SLV_BASE[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Scanning downwards lets the lowest matching index overwrite the others.
    always_comb begin
        hit_o  = 1'b0;
        slot_o = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_o  = 1'b1;
                slot_o = SLOT_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// Single-master to multi-slave bus fabric: decode, one outstanding slave access with a
// grant timeout, one-cycle completion pulse and a saturating error counter.
module bus_fabric
    import bus_pkg::*;
#(
    parameter int                          NUM_SLV  = 4,
    parameter int                          TIMEOUT  = 16,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE = DEF_SLV_BASE,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK = DEF_SLV_MASK
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       m_req_i,
    input  logic [ADDR_W-1:0]          m_addr_i,
    input  logic [DATA_W-1:0]          m_wdata_i,
    input  logic                       m_we_i,
    input  logic [1:0]                 m_hb_i,
    output logic                       m_gnt_o,
    output logic [DATA_W-1:0]          m_rdata_o,
    output logic                       m_err_o,
    output logic [7:0]                 err_cnt_o,
    output logic [NUM_SLV-1:0]         s_ce_o,
    output logic                       s_req_o,
    output logic                       s_we_o,
    output logic [ADDR_W-1:0]          s_addr_o,
    output logic [DATA_W-1:0]          s_wdata_o,
    output logic [1:0]                 s_hb_o,
    input  logic [NUM_SLV-1:0]         s_gnt_i,
    input  logic [NUM_SLV*DATA_W-1:0]  s_rdata_i
);

    localparam int         SLOT_W   = $clog2(NUM_SLV);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [1:0]          hb_q, hb_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                err_q, err_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic                dec_hit;
    logic [SLOT_W-1:0]   dec_slot;
    logic                gnt_sel;
    logic [DATA_W-1:0]   rdata_sel;
    logic [DATA_W-1:0]   s_rdata_w [NUM_SLV];

    bus_decode #(
        .NUM_SLV  (NUM_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK),
        .SLOT_W   (SLOT_W)
    ) u_decode (
        .addr_i (m_addr_i),
        .hit_o  (dec_hit),
        .slot_o (dec_slot)
    );

    generate
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_rdata
            assign s_rdata_w[gi] = s_rdata_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Only the selected slot's grant and data are ever looked at.
    assign gnt_sel   = s_gnt_i[slot_q];
    assign rdata_sel = s_rdata_w[slot_q];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        hb_d      = hb_q;
        slot_d    = slot_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            IDLE: begin
                if (m_req_i) begin
                    addr_d  = m_addr_i;
                    wdata_d = m_wdata_i;
                    we_d    = m_we_i;
                    hb_d    = m_hb_i;
                    cnt_d   = '0;
                    if (dec_hit) begin
                        slot_d  = dec_slot;
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = DONE;
                    end
                end
            end
            ACCESS: begin
                // A grant in the last allowed cycle still completes successfully.
                if (gnt_sel) begin
                    rdata_d = rdata_sel;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == TMO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                if (err_q && (err_cnt_q != 8'hFF)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            hb_q      <= '0;
            slot_q    <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            hb_q      <= hb_d;
            slot_q    <= slot_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Slave-side outputs are decoded from the state so a reset drops them immediately.
    always_comb begin
        s_ce_o    = '0;
        s_req_o   = 1'b0;
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        s_hb_o    = '0;
        if (state_q == ACCESS) begin
            s_ce_o[slot_q] = 1'b1;
            s_req_o        = 1'b1;
            s_we_o         = we_q;
            s_addr_o       = addr_q;
            s_wdata_o      = wdata_q;
            s_hb_o         = hb_q;
        end
    end

    assign m_gnt_o   = (state_q == DONE);
    assign m_err_o   = (state_q == DONE) && err_q;
    assign m_rdata_o = rdata_q;
    assign err_cnt_o = err_cnt_q;

endmodule
